// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: instruction push port, decoded issue outputs and processor completion
interface instruction_sequencer_if #(parameter int DEPTH = 4);
   logic                   in_valid;
   logic                   in_ready;
   logic [33:0]            in_instr;
   logic [2:0]             opcode;
   logic [4:0]             read_address1;
   logic [4:0]             read_address2;
   logic [4:0]             write_address;
   logic [15:0]            write_data;
   logic                   issue_valid;
   logic                   proc_done;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [15:0]            retired_count;
   modport master (
      output in_valid, in_instr, proc_done,
      input  in_ready, opcode, read_address1, read_address2, write_address, write_data,
             issue_valid, busy, fifo_count, retired_count
   );
   modport slave (
      input  in_valid, in_instr, proc_done,
      output in_ready, opcode, read_address1, read_address2, write_address, write_data,
             issue_valid, busy, fifo_count, retired_count
   );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: FIFO-buffered issue stage that waits for proc_done or a per-opcode latency budget
module instruction_sequencer #(
   parameter int DEPTH     = 4,
   parameter int SHORT_LAT = 4,
   parameter int LONG_LAT  = 24
) (
   input logic clk,
   input logic rst_n,
   instruction_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2((LONG_LAT > SHORT_LAT ? LONG_LAT : SHORT_LAT) + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t          state_q, state_d;
   logic [33:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic [33:0]     instr_q, instr_d;
   logic [CW-1:0]   wait_q, wait_d, lat_m1;
   logic [15:0]     ret_q, ret_d;
   logic            full, push, pop, done;
   assign full   = count_q == (AW+1)'(DEPTH);
   assign push   = bus.in_valid && !full;
   assign lat_m1 = instr_q[33:31] >= 3'd5 ? CW'(LONG_LAT - 1) : CW'(SHORT_LAT - 1);
   assign done   = state_q == WAIT && (bus.proc_done || wait_q == lat_m1);
   assign pop    = count_q != '0 && (state_q == IDLE || done);
   assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   // next state: pop into IDLE/ISSUE, count down the latency budget in WAIT
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ret_d   = ret_q;
      instr_d = pop ? mem_q[rd_ptr_q] : instr_q;
      unique case (state_q)
         IDLE:  state_d = pop ? ISSUE : IDLE;
         ISSUE: begin
            state_d = WAIT;
            wait_d  = '0;
         end
         default: begin
            state_d = !done ? WAIT : pop ? ISSUE : IDLE;
            wait_d  = done ? wait_q : wait_q + CW'(1);
            ret_d   = done ? ret_q + 16'd1 : ret_q;
         end
      endcase
   end
   // FIFO storage needs no reset; emptiness is tracked by the count
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_instr;
   end
   // control state, pointers and the held instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= '0;
         wait_q   <= '0;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_d;
         instr_q  <= instr_d;
         wait_q   <= wait_d;
         ret_q    <= ret_d;
      end
   end
   assign bus.in_ready      = !full;
   assign bus.fifo_count    = count_q;
   assign bus.opcode        = instr_q[33:31];
   assign bus.read_address1 = instr_q[30:26];
   assign bus.read_address2 = instr_q[25:21];
   assign bus.write_address = instr_q[20:16];
   assign bus.write_data    = instr_q[15:0];
   assign bus.issue_valid   = state_q == ISSUE;
   assign bus.busy          = state_q != IDLE;
   assign bus.retired_count = ret_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: vector table, directed corner sequences and random traffic against a queue model
module tb_instruction_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   instruction_sequencer_if #(.DEPTH(4)) bus ();
   instruction_sequencer #(.DEPTH(4), .SHORT_LAT(4), .LONG_LAT(24)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   typedef struct {
      logic        v;
      logic [33:0] ins;
      logic        pd;
      logic        e_iv;
      logic        e_busy;
      logic [2:0]  e_cnt;
      logic [15:0] e_ret;
      logic [4:0]  e_wa;
      logic [15:0] e_data;
   } vec_t;
   vec_t tbl [8];
   int pass_cnt = 0;
   int tot_cnt  = 0;
   int cyc      = 0;
   // reference: a queue of waiting words and the in-flight word with its age
   // (age -1: nothing in flight, 0: issue cycle, k>=1: k-th cycle of waiting)
   logic [33:0] mq [$];
   logic [33:0] m_cur;
   int          m_age;
   logic [15:0] m_ret;
   logic [15:0] issued [$];
   int          issued_cyc [$];
   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      tot_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (step %0d)", n, a, e, cyc);
   endfunction
   function automatic void model(logic v, logic [33:0] ins, logic pd, logic rn);
      bit take;
      if (!rn) begin
         mq.delete();
         m_age = -1;
         m_cur = '0;
         m_ret = '0;
         return;
      end
      take = v && mq.size() < 4;
      if (m_age < 0) begin
         if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_age = 0;
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (pd || m_age == (m_cur[33:31] >= 3'd5 ? 24 : 4)) begin
         m_ret++;
         if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_age = 0;
         end else m_age = -1;
      end else m_age++;
      if (take) mq.push_back(ins);
   endfunction
   task automatic step(input logic v, input logic [33:0] ins, input logic pd, input logic rn);
      bus.in_valid = v;
      bus.in_instr = ins;
      bus.proc_done = pd;
      rst_n = rn;
      @(posedge clk);
      model(v, ins, pd, rn);
      @(negedge clk);
      cyc++;
      if (bus.issue_valid) begin
         issued.push_back(bus.write_data);
         issued_cyc.push_back(cyc);
      end
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 4));
      chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
      chk("busy", 64'(bus.busy), 64'(m_age >= 0));
      chk("issue_valid", 64'(bus.issue_valid), 64'(m_age == 0));
      chk("retired_count", 64'(bus.retired_count), 64'(m_ret));
      chk("fields", 64'({bus.opcode, bus.read_address1, bus.read_address2, bus.write_address, bus.write_data}), 64'(m_cur));
   endtask
   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      issued.delete();
      issued_cyc.delete();
   endtask
   // idles the input, optionally pulses proc_done in the given WAIT cycle, counts busy cycles
   task automatic run_until_idle(input int pd_at, output int nb);
      int w = 0;
      logic pd;
      nb = 0;
      for (int i = 0; i < 300; i++) begin
         if (nb > 0 && !bus.busy) break;
         pd = bus.busy && !bus.issue_valid && w == pd_at;
         if (bus.busy && !bus.issue_valid) w++;
         step(1'b0, '0, pd, 1'b1);
         if (bus.busy) nb++;
      end
   endtask
   initial begin
      int nb;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.proc_done = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      // T1 reset
      do_reset();
      do_reset();
      chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t1_fifo_count", 64'(bus.fifo_count), 64'd0);
      chk("t1_busy_iv", 64'({bus.busy, bus.issue_valid}), 64'd0);
      chk("t1_retired", 64'(bus.retired_count), 64'd0);
      chk("t1_fields", 64'({bus.opcode, bus.read_address1, bus.read_address2, bus.write_address, bus.write_data}), 64'd0);
      // T2 single issue, table-driven
      tbl[0] = '{1'b1, {3'd0, 5'd0, 5'd0, 5'd7, 16'h00AB}, 1'b0, 1'b0, 1'b0, 3'd1, 16'd0, 5'd0, 16'h0000};
      tbl[1] = '{1'b0, 34'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 5'd7, 16'h00AB};
      for (int i = 2; i < 6; i++)
         tbl[i] = '{1'b0, 34'd0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 5'd7, 16'h00AB};
      tbl[6] = '{1'b0, 34'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1, 5'd7, 16'h00AB};
      tbl[7] = '{1'b0, 34'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1, 5'd7, 16'h00AB};
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].ins, tbl[i].pd, 1'b1);
         chk($sformatf("t2_iv_%0d", i), 64'(bus.issue_valid), 64'(tbl[i].e_iv));
         chk($sformatf("t2_busy_%0d", i), 64'(bus.busy), 64'(tbl[i].e_busy));
         chk($sformatf("t2_cnt_%0d", i), 64'(bus.fifo_count), 64'(tbl[i].e_cnt));
         chk($sformatf("t2_ret_%0d", i), 64'(bus.retired_count), 64'(tbl[i].e_ret));
         chk($sformatf("t2_wa_%0d", i), 64'(bus.write_address), 64'(tbl[i].e_wa));
         chk($sformatf("t2_data_%0d", i), 64'(bus.write_data), 64'(tbl[i].e_data));
      end
      // T3 long op: full 24-cycle wait, then early completion in WAIT cycle 10
      do_reset();
      step(1'b1, {3'd5, 5'd1, 5'd2, 5'd3, 16'h0000}, 1'b0, 1'b1);
      run_until_idle(-1, nb);
      chk("t3_long_busy", 64'(nb), 64'd25);
      chk("t3_fields", 64'({bus.opcode, bus.read_address1, bus.read_address2, bus.write_address}), 64'({3'd5, 5'd1, 5'd2, 5'd3}));
      step(1'b1, {3'd5, 5'd4, 5'd5, 5'd6, 16'h0001}, 1'b0, 1'b1);
      run_until_idle(10, nb);
      chk("t3_early_busy", 64'(nb), 64'd12);
      chk("t3_retired", 64'(bus.retired_count), 64'd2);
      // T4 full FIFO: one in flight, four queued, sixth word dropped
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, {(i == 0 ? 3'd5 : 3'd2), 5'd0, 5'd0, 5'd1, 16'(i)}, 1'b0, 1'b1);
         if (i == 4) chk("t4_full_cnt", 64'({bus.fifo_count, bus.in_ready}), 64'({3'd4, 1'b0}));
      end
      chk("t4_after_drop", 64'({bus.fifo_count, bus.in_ready}), 64'({3'd4, 1'b0}));
      run_until_idle(-1, nb);
      chk("t4_issued_n", 64'(issued.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t4_order_%0d", i), 64'(i < issued.size() ? issued[i] : 16'hFFFF), 64'(i));
      chk("t4_retired", 64'(bus.retired_count), 64'd5);
      // T5 back-to-back issue spacing
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, {3'd1, 5'd0, 5'd0, 5'd2, 16'(i)}, 1'b0, 1'b1);
      run_until_idle(-1, nb);
      chk("t5_issued_n", 64'(issued_cyc.size()), 64'd3);
      for (int i = 1; i < 3; i++)
         chk($sformatf("t5_gap_%0d", i), 64'(i < issued_cyc.size() ? issued_cyc[i] - issued_cyc[i-1] : 0), 64'd5);
      chk("t5_retired", 64'(bus.retired_count), 64'd3);
      // T6 reset in the middle of a wait abandons the instruction
      do_reset();
      step(1'b1, {3'd6, 5'd9, 5'd9, 5'd9, 16'h1234}, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
      chk("t6_in_wait", 64'({bus.busy, bus.issue_valid}), 64'({1'b1, 1'b0}));
      step(1'b1, {3'd2, 5'd1, 5'd1, 5'd1, 16'h5555}, 1'b0, 1'b0);
      chk("t6_retired", 64'(bus.retired_count), 64'd0);
      chk("t6_fifo", 64'(bus.fifo_count), 64'd0);
      chk("t6_opcode", 64'(bus.opcode), 64'd0);
      chk("t6_busy", 64'(bus.busy), 64'd0);
      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         step($urandom_range(1, 0) == 1, {$urandom_range(7, 0), 31'($urandom)},
              $urandom_range(7, 0) == 0, $urandom_range(299, 0) != 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
